// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, sequencer state encoding and
// helpers used by both the special-op sequencer and the control unit.
package cpu_pkg;

    localparam int OP_W = 5;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_NOP          = 5'b0_0000;
    localparam opcode_t OP_POP_FLAGS    = 5'b0_1111;
    localparam opcode_t OP_LDM          = 5'b1_0010;
    localparam opcode_t OP_PUSH_PC_LOW  = 5'b1_0101;
    localparam opcode_t OP_PUSH_PC_HIGH = 5'b1_0110;
    localparam opcode_t OP_POP_PC_LOW   = 5'b1_0111;
    localparam opcode_t OP_CALL         = 5'b1_1100;
    localparam opcode_t OP_RET          = 5'b1_1101;
    localparam opcode_t OP_RTI          = 5'b1_1110;
    localparam opcode_t OP_PUSH_FLAGS   = 5'b1_1111;

    typedef enum logic [2:0] {
        SEQ_IDLE     = 3'd0,
        SEQ_CALL_PCH = 3'd1,
        SEQ_RET_PCL  = 3'd2,
        SEQ_RTI_PCL  = 3'd3,
        SEQ_RTI_FLG  = 3'd4,
        SEQ_INT_FLG  = 3'd5,
        SEQ_INT_PCL  = 3'd6,
        SEQ_INT_PCH  = 3'd7
    } seq_state_t;

    // Opcode the fetch buffer receives while the sequencer sits in a state.
    function automatic opcode_t seq_inject_op(input seq_state_t st);
        case (st)
            SEQ_CALL_PCH: seq_inject_op = OP_PUSH_PC_HIGH;
            SEQ_RET_PCL:  seq_inject_op = OP_POP_PC_LOW;
            SEQ_RTI_PCL:  seq_inject_op = OP_POP_PC_LOW;
            SEQ_RTI_FLG:  seq_inject_op = OP_POP_FLAGS;
            SEQ_INT_FLG:  seq_inject_op = OP_PUSH_FLAGS;
            SEQ_INT_PCL:  seq_inject_op = OP_PUSH_PC_LOW;
            SEQ_INT_PCH:  seq_inject_op = OP_PUSH_PC_HIGH;
            default:      seq_inject_op = OP_NOP;
        endcase
    endfunction

    // Opcodes that must not be split from their follow-on words by an interrupt.
    function automatic logic blocks_interrupt(input opcode_t op);
        blocks_interrupt = (op == OP_LDM) || (op == OP_CALL) ||
                           (op == OP_RET) || (op == OP_RTI);
    endfunction

endpackage

// File: rtl/special_op_sequencer.sv
// Injects the follow-on stack opcodes for CALL/RET/RTI and hardware
// interrupts into the fetch buffer, one per cycle, while holding the PC.
module special_op_sequencer
    import cpu_pkg::*;
#(
    parameter int N = OP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] dec_op,
    input  logic         dec_valid,
    input  logic         int_req,
    input  logic         stall,
    output logic         inject_valid,
    output logic [N-1:0] inject_op,
    output logic         fetch_hold,
    output logic         int_ack,
    output logic         busy
);

    seq_state_t   state_reg, state_next;
    seq_state_t   launch_state;
    logic         launch_accept;
    logic         accept;
    logic         int_seen;
    logic         int_pending_reg, int_pending_next;
    logic         inject_valid_reg, inject_valid_next;
    logic [N-1:0] inject_op_reg, inject_op_next;
    logic         fetch_hold_reg, fetch_hold_next;
    logic         int_ack_reg, int_ack_next;
    logic         busy_reg, busy_next;

    assign int_seen = int_pending_reg | int_req;

    // Decision taken from IDLE, and also from the last state of every
    // sequence so back-to-back work starts without a dead cycle.
    always_comb begin
        launch_state  = SEQ_IDLE;
        launch_accept = 1'b0;
        if (dec_valid && dec_op == OP_CALL) begin
            launch_state = SEQ_CALL_PCH;
        end else if (dec_valid && dec_op == OP_RET) begin
            launch_state = SEQ_RET_PCL;
        end else if (dec_valid && dec_op == OP_RTI) begin
            launch_state = SEQ_RTI_PCL;
        end else if (int_seen && !(dec_valid && blocks_interrupt(dec_op))) begin
            launch_state  = SEQ_INT_FLG;
            launch_accept = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        if (!stall) begin
            case (state_reg)
                SEQ_RTI_PCL: state_next = SEQ_RTI_FLG;
                SEQ_INT_FLG: state_next = SEQ_INT_PCL;
                SEQ_INT_PCL: state_next = SEQ_INT_PCH;
                default: begin
                    state_next = launch_state;
                    accept     = launch_accept;
                end
            endcase
        end
    end

    // Outputs are registered copies of the next state's Moore values; a
    // request arriving during a stall is still remembered.
    always_comb begin
        int_pending_next  = int_seen & ~accept;
        busy_next         = (state_next != SEQ_IDLE);
        inject_valid_next = busy_next;
        fetch_hold_next   = busy_next;
        inject_op_next    = seq_inject_op(state_next);
        int_ack_next      = accept;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= SEQ_IDLE;
            int_pending_reg  <= 1'b0;
            inject_valid_reg <= 1'b0;
            inject_op_reg    <= OP_NOP;
            fetch_hold_reg   <= 1'b0;
            int_ack_reg      <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            int_pending_reg  <= int_pending_next;
            inject_valid_reg <= inject_valid_next;
            inject_op_reg    <= inject_op_next;
            fetch_hold_reg   <= fetch_hold_next;
            int_ack_reg      <= int_ack_next;
            busy_reg         <= busy_next;
        end
    end

    assign inject_valid = inject_valid_reg;
    assign inject_op    = inject_op_reg;
    assign fetch_hold   = fetch_hold_reg;
    assign int_ack      = int_ack_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_special_op_sequencer.sv
// Directed bench for special_op_sequencer: CALL/RET/RTI sequences, interrupt
// acceptance and deferral, merging, stall freeze and asynchronous reset abort.
module tb_special_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] dec_op;
    logic       dec_valid;
    logic       int_req;
    logic       stall;
    logic       inject_valid;
    logic [4:0] inject_op;
    logic       fetch_hold;
    logic       int_ack;
    logic       busy;

    int checks = 0;
    int errors = 0;

    special_op_sequencer #(.N(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .dec_op       (dec_op),
        .dec_valid    (dec_valid),
        .int_req      (int_req),
        .stall        (stall),
        .inject_valid (inject_valid),
        .inject_op    (inject_op),
        .fetch_hold   (fetch_hold),
        .int_ack      (int_ack),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compares {inject_valid, inject_op, fetch_hold, int_ack, busy}.
    task automatic expect_out(input string tag, input logic iv, input logic [4:0] op,
                              input logic fh, input logic ack, input logic bsy);
        logic [8:0] obs;
        logic [8:0] exp;
        obs = {inject_valid, inject_op, fetch_hold, int_ack, busy};
        exp = {iv, op, fh, ack, bsy};
        checks++;
        assert (obs === exp)
            $display("[%0t] %-14s iv/op/fh/ack/busy = %b", $time, tag, obs);
        else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        dec_op    = 5'b0_0000;
        dec_valid = 1'b0;
        int_req   = 1'b0;
        stall     = 1'b0;
        tick();
        expect_out("reset", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        expect_out("idle", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // CALL: one injected PUSH_PC_HIGH
        dec_op = 5'b1_1100; dec_valid = 1'b1;
        tick();
        dec_op = 5'b0_0000; dec_valid = 1'b0;
        expect_out("call_pch", 1'b1, 5'b1_0110, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("call_done", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // RET: one injected POP_PC_LOW
        dec_op = 5'b1_1101; dec_valid = 1'b1;
        tick();
        dec_op = 5'b0_0000; dec_valid = 1'b0;
        expect_out("ret_pcl", 1'b1, 5'b1_0111, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("ret_done", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // CALL opcode on the bus but not valid: no trigger
        dec_op = 5'b1_1100; dec_valid = 1'b0;
        tick();
        dec_op = 5'b0_0000;
        expect_out("call_invalid", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // RTI: POP_PC_LOW then POP_FLAGS
        dec_op = 5'b1_1110; dec_valid = 1'b1;
        tick();
        dec_op = 5'b0_0000; dec_valid = 1'b0;
        expect_out("rti_pcl", 1'b1, 5'b1_0111, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("rti_flg", 1'b1, 5'b0_1111, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("rti_done", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // One-cycle interrupt pulse with ADD in decode
        dec_op = 5'b0_1001; dec_valid = 1'b1; int_req = 1'b1;
        tick();
        int_req = 1'b0;
        expect_out("int_flg", 1'b1, 5'b1_1111, 1'b1, 1'b1, 1'b1);
        tick();
        expect_out("int_pcl", 1'b1, 5'b1_0101, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("int_pch", 1'b1, 5'b1_0110, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("int_done", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // LDM in decode defers acceptance by one cycle
        dec_op = 5'b1_0010; dec_valid = 1'b1; int_req = 1'b1;
        tick();
        int_req = 1'b0; dec_op = 5'b0_0011;
        expect_out("ldm_defer", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);
        tick();
        dec_valid = 1'b0; dec_op = 5'b0_0000;
        expect_out("ldm_int_flg", 1'b1, 5'b1_1111, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        tick();
        expect_out("ldm_int_done", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // CALL beats a simultaneous interrupt; INT follows with no gap
        dec_op = 5'b1_1100; dec_valid = 1'b1; int_req = 1'b1;
        tick();
        dec_op = 5'b0_0000; dec_valid = 1'b0; int_req = 1'b0;
        expect_out("callint_pch", 1'b1, 5'b1_0110, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("callint_flg", 1'b1, 5'b1_1111, 1'b1, 1'b1, 1'b1);
        tick();
        expect_out("callint_pcl", 1'b1, 5'b1_0101, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("callint_pchi", 1'b1, 5'b1_0110, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("callint_done", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // RTI with two merged requests: a single INT sequence afterwards
        dec_op = 5'b1_1110; dec_valid = 1'b1; int_req = 1'b1;
        tick();
        dec_op = 5'b0_0000; dec_valid = 1'b0;
        expect_out("rtiint_pcl", 1'b1, 5'b1_0111, 1'b1, 1'b0, 1'b1);
        tick();
        int_req = 1'b0;
        expect_out("rtiint_flg", 1'b1, 5'b0_1111, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("rtiint_iflg", 1'b1, 5'b1_1111, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        expect_out("rtiint_ipch", 1'b1, 5'b1_0110, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("merge_single", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        // Stall during INT_PCL, request latched while stalled, reset mid-INT_PCH
        int_req = 1'b1;
        tick();
        int_req = 1'b0;
        expect_out("st_int_flg", 1'b1, 5'b1_1111, 1'b1, 1'b1, 1'b1);
        tick();
        expect_out("st_int_pcl", 1'b1, 5'b1_0101, 1'b1, 1'b0, 1'b1);
        stall = 1'b1; int_req = 1'b1;
        tick();
        int_req = 1'b0;
        expect_out("stall_hold1", 1'b1, 5'b1_0101, 1'b1, 1'b0, 1'b1);
        tick();
        expect_out("stall_hold2", 1'b1, 5'b1_0101, 1'b1, 1'b0, 1'b1);
        stall = 1'b0;
        tick();
        expect_out("st_int_pch", 1'b1, 5'b1_0110, 1'b1, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_abort", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        expect_out("post_reset1", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);
        tick();
        expect_out("no_pending", 1'b0, 5'b0_0000, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
